// File: rtl/hamming74_decoder.sv
`default_nettype none
// ============================================================================
// hamming74_decoder : Hamming(7,4) single-error-correcting decoder, 1-cycle
//                     registered outputs, saturating corrected-word counter.
// Revision 1.0
// ============================================================================
module hamming74_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [6:0]       encoded_data,
  input  logic             err_count_clr,
  output logic             out_valid,
  output logic [3:0]       data,
  output logic [2:0]       error_position,
  output logic             is_error,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       w_syndrome;
  logic [6:0]       w_flip;
  logic [6:0]       w_corrected;
  logic [3:0]       w_data;
  logic             w_is_error;

  logic             r_out_valid;
  logic [3:0]       r_data;
  logic [2:0]       r_error_position;
  logic             r_is_error;
  logic [CNT_W-1:0] r_err_count;

  // encoded_data[i] is Hamming position i+1
  assign w_syndrome[0] = encoded_data[0] ^ encoded_data[2] ^ encoded_data[4] ^ encoded_data[6];
  assign w_syndrome[1] = encoded_data[1] ^ encoded_data[2] ^ encoded_data[5] ^ encoded_data[6];
  assign w_syndrome[2] = encoded_data[3] ^ encoded_data[4] ^ encoded_data[5] ^ encoded_data[6];
  assign w_is_error    = (w_syndrome != 3'd0);

  // A zero syndrome matches no position, so nothing is flipped
  always_comb begin
    w_flip = 7'd0;
    for (int i = 0; i < 7; i++) begin
      w_flip[i] = (w_syndrome == 3'(i + 1));
    end
  end

  assign w_corrected = encoded_data ^ w_flip;
  assign w_data      = {w_corrected[6], w_corrected[5], w_corrected[4], w_corrected[2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid      <= 1'b0;
      r_data           <= 4'd0;
      r_error_position <= 3'd0;
      r_is_error       <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_data           <= w_data;
        r_error_position <= w_syndrome;
        r_is_error       <= w_is_error;
      end
    end
  end

  // Clear wins over a simultaneous increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (err_count_clr) begin
      r_err_count <= '0;
    end else if (in_valid && w_is_error && (r_err_count != c_CNT_MAX)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign out_valid      = r_out_valid;
  assign data           = r_data;
  assign error_position = r_error_position;
  assign is_error       = r_is_error;
  assign err_count      = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_hamming74_decoder.sv
`default_nettype none
// Directed testbench for hamming74_decoder (counter width 2 for saturation).
module tb_hamming74_decoder;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [6:0]       encoded_data = 7'd0;
  logic             err_count_clr = 1'b0;
  logic             out_valid;
  logic [3:0]       data;
  logic [2:0]       error_position;
  logic             is_error;
  logic [CNT_W-1:0] err_count;

  int n_asserts = 0;
  int n_fail    = 0;

  hamming74_decoder #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .encoded_data   (encoded_data),
    .err_count_clr  (err_count_clr),
    .out_valid      (out_valid),
    .data           (data),
    .error_position (error_position),
    .is_error       (is_error),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge
  task automatic step(input logic [6:0] word, input logic valid, input logic clr);
    @(negedge clk);
    encoded_data  = word;
    in_valid      = valid;
    err_count_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [3:0] d, input logic [2:0] pos);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " data"}, 32'(data), 32'(d));
    check({tag, " pos"}, 32'(error_position), 32'(pos));
    check({tag, " is_error"}, 32'(is_error), 32'(pos != 3'd0));
  endtask

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  initial begin
    logic [6:0] cw;
    #2;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset data", 32'(data), 32'd0);
    check("reset pos", 32'(error_position), 32'd0);
    check("reset is_error", 32'(is_error), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean codewords, back to back
    step(7'b0110011, 1'b1, 1'b0); check_result("clean0", 4'd6, 3'd0);
    step(7'b1010010, 1'b1, 1'b0); check_result("clean1", 4'd10, 3'd0);
    step(7'b1111000, 1'b1, 1'b0); check_result("clean2", 4'd14, 3'd0);
    step(7'b0011001, 1'b1, 1'b0); check_result("clean3", 4'd2, 3'd0);
    check("clean err_count", 32'(err_count), 32'd0);

    // Single-bit errors on data and parity positions
    step(7'b0100011, 1'b1, 1'b0); check_result("p5 flip", 4'd6, 3'd5);
    check("p5 err_count", 32'(err_count), 32'd1);
    step(7'b0110010, 1'b1, 1'b0); check_result("p1 flip", 4'd6, 3'd1);
    check("p1 err_count", 32'(err_count), 32'd2);
    step(7'b0111011, 1'b1, 1'b0); check_result("p4 flip", 4'd6, 3'd4);
    check("p4 err_count", 32'(err_count), 32'd3);

    // Exhaustive: every data value with no error and every single flip
    for (int d = 0; d < 16; d++) begin
      for (int e = 0; e < 8; e++) begin
        cw = encode(4'(d));
        if (e != 0) cw[e-1] = ~cw[e-1];
        step(cw, 1'b1, 1'b0);
        check_result($sformatf("exh d%0d e%0d", d, e), 4'(d), 3'(e));
      end
    end

    // Counter: clear, then saturate at 3
    step(7'b0110011, 1'b1, 1'b1);
    check("clr err_count", 32'(err_count), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step(7'b0100011, 1'b1, 1'b0);
      check($sformatf("sat %0d err_count", k), 32'(err_count), (k < 3) ? 32'(k) : 32'd3);
    end
    step(7'b0110010, 1'b1, 1'b1);
    check("clr+err err_count", 32'(err_count), 32'd0);
    check("clr+err is_error", 32'(is_error), 32'd1);

    // Gaps: out_valid drops, results hold
    step(7'b1111001, 1'b1, 1'b0); check_result("pre-gap", 4'd14, 3'd1);
    for (int g = 0; g < 2; g++) begin
      step(7'b0000000, 1'b0, 1'b0);
      check("gap out_valid", 32'(out_valid), 32'd0);
      check("gap data", 32'(data), 32'd14);
      check("gap pos", 32'(error_position), 32'd1);
      check("gap is_error", 32'(is_error), 32'd1);
      check("gap err_count", 32'(err_count), 32'd1);
    end

    // Asynchronous reset mid-stream
    step(7'b1010010, 1'b1, 1'b0); check_result("pre-reset", 4'd10, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async out_valid", 32'(out_valid), 32'd0);
    check("async data", 32'(data), 32'd0);
    check("async pos", 32'(error_position), 32'd0);
    check("async is_error", 32'(is_error), 32'd0);
    check("async err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    check("held reset out_valid", 32'(out_valid), 32'd0);
    step(7'b0000000, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset idle out_valid", 32'(out_valid), 32'd0);
    step(7'b0011000, 1'b1, 1'b0); check_result("post-reset first", 4'd2, 3'd1);
    check("post-reset err_count", 32'(err_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
